// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  // One buffered fetch result: the word and the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Sequential successor; wraps 32'hFFFF_FFFC to 0 through natural overflow.
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Branch targets are forced onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetch_entry_t with a synchronous flush.
// The head is presented straight from storage, so it is stable while
// the consumer stalls. An empty buffer presents an all-zero entry.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               din,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy bookkeeping; flush discards everything, including
  // a push that lands in the same cycle.
  // NOTE: sequential state is always written with <= so every flop samples
  // values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage write.
  // NOTE: the storage array has no reset; the occupancy count alone decides
  // which entries are meaningful, so clearing data would only cost area.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // Status flags and the head view (zero while empty).
  always_comb begin
    empty = (count == '0);
    full  = (count == CW'(DEPTH));
    head  = empty ? '0 : mem[rd_ptr];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency memory
// requests under a credit limit, buffers returned words with their PCs and
// hands them downstream on a valid/ready handshake. A taken redirect
// reloads the PC and flushes every piece of stale work.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   inst_pc,
  output logic [PC_W-1:0]   inst_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int UW = CW + 1;

  logic            run;
  logic            inflight;
  logic            kill;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;

  logic            pop;
  logic            push;
  logic            redir;
  logic [UW-1:0]   used;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Run flag: fetch starts on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Credit check, handshake and redirect qualification.
  // Occupancy plus the outstanding request, less the word leaving this
  // cycle, must stay below DEPTH so a response always finds a free slot.
  always_comb begin
    pop        = !fifo_empty && inst_ready;
    redir      = run && redirect_valid;
    used       = UW'(fifo_count) + UW'(inflight) - UW'(pop);
    imem_req   = run && !redirect_valid && (used < UW'(DEPTH));
    imem_addr  = fetch_pc;
    push       = inflight && !kill;
    push_entry = '{pc: inflight_pc, inst: imem_rdata};
  end

  // PC, in-flight tracking and kill of a response made stale by a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      kill        <= 1'b0;
    end else begin
      inflight <= imem_req;
      kill     <= redir && inflight;
      if (imem_req) inflight_pc <= fetch_pc;
      if (redir)         fetch_pc <= align_pc(redirect_pc);
      else if (imem_req) fetch_pc <= next_pc(fetch_pc);
    end
  end

  // The credit rule guarantees a response never meets a full buffer.
  push_into_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redir),
    .din   (push_entry),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Downstream view comes straight from the buffer head.
  always_comb begin
    inst_valid    = !fifo_empty;
    inst_out      = head.inst;
    inst_pc       = head.pc;
    inst_pc_plus4 = next_pc(head.pc);
  end

endmodule
